// File: rtl/cv_pad_encoder_if.sv
// ---------------------------------------------------------------------------
// cv_pad_encoder_if
// Bundles the per-pad controller signals between the joystick-swap mux /
// console side and cv_pad_encoder.
//   joy_i       32*NUM_PADS  joystick words, pad i = joy_i[32i+31:32i]
//   turbo_en_i  NUM_PADS     per-pad turbo enable
//   spin_en_i   NUM_PADS     per-pad spinner enable
//   ctrl_p5_i   NUM_PADS     keypad-select strobe, active-low
//   ctrl_p8_i   NUM_PADS     joystick-select strobe, active-low
//   ctrl_o      4*NUM_PADS   {P1,P2,P3,P4} per pad, active-low
//   ctrl_p6_o   NUM_PADS     fire line, active-low
//   ctrl_p7_o   NUM_PADS     spinner quadrature A
//   ctrl_p9_o   NUM_PADS     spinner quadrature B
// master: drives joystick words and strobes; slave: the encoder.
// ---------------------------------------------------------------------------
interface cv_pad_encoder_if #(
  parameter int NUM_PADS = 2
);
  logic [32*NUM_PADS-1:0] joy_i;
  logic [NUM_PADS-1:0]    turbo_en_i;
  logic [NUM_PADS-1:0]    spin_en_i;
  logic [NUM_PADS-1:0]    ctrl_p5_i;
  logic [NUM_PADS-1:0]    ctrl_p8_i;
  logic [4*NUM_PADS-1:0]  ctrl_o;
  logic [NUM_PADS-1:0]    ctrl_p6_o;
  logic [NUM_PADS-1:0]    ctrl_p7_o;
  logic [NUM_PADS-1:0]    ctrl_p9_o;

  modport master (
    output joy_i, turbo_en_i, spin_en_i, ctrl_p5_i, ctrl_p8_i,
    input  ctrl_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
  );

  modport slave (
    input  joy_i, turbo_en_i, spin_en_i, ctrl_p5_i, ctrl_p8_i,
    output ctrl_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
  );
endinterface

// File: rtl/cv_pad_encoder.sv
// ---------------------------------------------------------------------------
// cv_pad_encoder
// Converts NUM_PADS MiSTer joystick words into ColecoVision controller-port
// signals, with keypad hold stretching, per-pad turbo fire and Super Action
// spinner quadrature emulation. All outputs are registered (1 clk latency).
//   clk_i         system clock
//   reset_n_i     synchronous reset, active-low
//   clk_en_i      10.7 MHz clock enable, spinner timebase
//   frame_tick_i  one-cycle strobe per video frame
//   pads          cv_pad_encoder_if.slave (joystick words, strobes, outputs)
// ---------------------------------------------------------------------------
module cv_pad_encoder #(
  parameter int NUM_PADS   = 2,
  parameter int HOLD_TICKS = 4,
  parameter int TURBO_DIV  = 3,
  parameter int SPIN_DIV   = 8192
) (
  input logic            clk_i,
  input logic            reset_n_i,
  input logic            clk_en_i,
  input logic            frame_tick_i,
  cv_pad_encoder_if.slave pads
);

  // The hold counter must be able to hold HOLD_TICKS itself; the other two
  // counters only ever reach DIV-1.
  localparam int HOLD_W  = ($clog2(HOLD_TICKS + 1) < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam int TURBO_W = ($clog2(TURBO_DIV) < 1) ? 1 : $clog2(TURBO_DIV);
  localparam int SPIN_W  = ($clog2(SPIN_DIV) < 1) ? 1 : $clog2(SPIN_DIV);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_TICKS);
  localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_DIV - 1);
  localparam logic [SPIN_W-1:0]  SPIN_LAST  = SPIN_W'(SPIN_DIV - 1);

  localparam logic [3:0] KEY_NONE = 4'b1111;

  // Quadrature state is {P7,P9}; clockwise walks 11->10->00->01.
  typedef enum logic [1:0] {
    QUAD_11 = 2'b11,
    QUAD_10 = 2'b10,
    QUAD_00 = 2'b00,
    QUAD_01 = 2'b01
  } quad_t;

  function automatic logic [3:0] key_encode(input logic [21:0] j);
    logic [3:0] code;
    if      (j[8])  code = 4'b0011;  // 0
    else if (j[9])  code = 4'b1110;  // 1
    else if (j[10]) code = 4'b1101;  // 2
    else if (j[11]) code = 4'b0110;  // 3
    else if (j[12]) code = 4'b0001;  // 4
    else if (j[13]) code = 4'b1001;  // 5
    else if (j[14]) code = 4'b0111;  // 6
    else if (j[15]) code = 4'b1100;  // 7
    else if (j[16]) code = 4'b1000;  // 8
    else if (j[17]) code = 4'b1011;  // 9
    else if (j[6])  code = 4'b1010;  // *
    else if (j[7])  code = 4'b0101;  // #
    else if (j[18]) code = 4'b0100;  // Purple
    else if (j[19]) code = 4'b0010;  // Blue
    else            code = KEY_NONE;
    return code;
  endfunction

  function automatic quad_t quad_step(input quad_t q, input logic cw);
    quad_t n;
    case (q)
      QUAD_11: n = cw ? QUAD_10 : QUAD_01;
      QUAD_10: n = cw ? QUAD_00 : QUAD_11;
      QUAD_00: n = cw ? QUAD_01 : QUAD_10;
      QUAD_01: n = cw ? QUAD_11 : QUAD_00;
      default: n = QUAD_11;
    endcase
    return n;
  endfunction

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    logic [21:0]        joy;
    logic               p5_n;
    logic               p8_n;

    logic [3:0]         raw;
    logic [3:0]         key;
    logic [3:0]         dir;
    logic               fire1;
    logic               fire2;

    logic [3:0]         latch_q, latch_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               phase_q, phase_d;
    logic [TURBO_W-1:0] turbo_q, turbo_d;
    quad_t              quad_q, quad_d;
    logic [SPIN_W-1:0]  spin_q, spin_d;
    logic [3:0]         nib_q, nib_d;
    logic               p6_q, p6_d;

    assign joy  = pads.joy_i[32*g +: 22];
    assign p5_n = pads.ctrl_p5_i[g];
    assign p8_n = pads.ctrl_p8_i[g];

    always_comb begin
      latch_d = latch_q;
      hold_d  = hold_q;
      phase_d = phase_q;
      turbo_d = turbo_q;
      quad_d  = quad_q;
      spin_d  = spin_q;
      raw     = key_encode(joy);

      // Hold stretch: any pressed code wins at once; a release only expires
      // on the frame tick that finds the counter already at zero.
      if (raw != KEY_NONE) begin
        latch_d = raw;
        hold_d  = HOLD_LOAD;
      end else if (HOLD_TICKS == 0) begin
        latch_d = KEY_NONE;
        hold_d  = '0;
      end else if (frame_tick_i) begin
        if (hold_q != '0) hold_d  = hold_q - 1'b1;
        else              latch_d = KEY_NONE;
      end

      // Turbo: phase starts at 1 so the first press fires immediately.
      if (!pads.turbo_en_i[g] || !(joy[4] || joy[5])) begin
        phase_d = 1'b1;
        turbo_d = '0;
      end else if (frame_tick_i) begin
        if (turbo_q == TURBO_LAST) begin
          turbo_d = '0;
          phase_d = ~phase_q;
        end else begin
          turbo_d = turbo_q + 1'b1;
        end
      end

      fire1 = joy[4] & phase_d;
      fire2 = joy[5] & phase_d;

      // Outputs are built from the next-state values so every input reaches
      // the pins exactly one clock later.
      key   = p5_n ? KEY_NONE : latch_d;
      dir   = p8_n ? 4'b1111  : ~{joy[3], joy[0], joy[2], joy[1]};
      nib_d = key & dir;
      p6_d  = ~(~p5_n & fire2) & ~(~p8_n & fire1);

      // Spinner: bit 21 = CW, bit 20 = CCW. The counter is shared across
      // directions so a reversal keeps the partial count.
      if (!pads.spin_en_i[g]) begin
        quad_d = QUAD_11;
        spin_d = '0;
      end else if (joy[20] ^ joy[21]) begin
        if (clk_en_i) begin
          if (spin_q == SPIN_LAST) begin
            spin_d = '0;
            quad_d = quad_step(quad_q, joy[21]);
          end else begin
            spin_d = spin_q + 1'b1;
          end
        end
      end else begin
        spin_d = '0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        latch_q <= KEY_NONE;
        hold_q  <= '0;
        phase_q <= 1'b1;
        turbo_q <= '0;
        quad_q  <= QUAD_11;
        spin_q  <= '0;
        nib_q   <= 4'b1111;
        p6_q    <= 1'b1;
      end else begin
        latch_q <= latch_d;
        hold_q  <= hold_d;
        phase_q <= phase_d;
        turbo_q <= turbo_d;
        quad_q  <= quad_d;
        spin_q  <= spin_d;
        nib_q   <= nib_d;
        p6_q    <= p6_d;
      end
    end

    assign pads.ctrl_o[4*g +: 4] = nib_q;
    assign pads.ctrl_p6_o[g]     = p6_q;
    assign pads.ctrl_p7_o[g]     = quad_q[1];
    assign pads.ctrl_p9_o[g]     = quad_q[0];
  end

endmodule

// File: tb/tb_cv_pad_encoder.sv
// ---------------------------------------------------------------------------
// tb_cv_pad_encoder
// Directed bench for cv_pad_encoder: a table of single-cycle keypad /
// joystick / fire vectors on pad 0, then hand-written sequences for reset,
// hold stretching, override, turbo, spinner quadrature, multi-pad isolation
// and the HOLD_TICKS=0 variant.
// ---------------------------------------------------------------------------
module tb_cv_pad_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic ft;

  int n_vec = 0;
  int n_err = 0;

  cv_pad_encoder_if #(.NUM_PADS(4)) bus ();
  cv_pad_encoder_if #(.NUM_PADS(1)) bus0 ();

  cv_pad_encoder #(
    .NUM_PADS(4), .HOLD_TICKS(4), .TURBO_DIV(3), .SPIN_DIV(4)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .clk_en_i(clk_en),
    .frame_tick_i(ft), .pads(bus.slave)
  );

  cv_pad_encoder #(
    .NUM_PADS(1), .HOLD_TICKS(0), .TURBO_DIV(1), .SPIN_DIV(1)
  ) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .clk_en_i(clk_en),
    .frame_tick_i(ft), .pads(bus0.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] joy;
    logic        p5;
    logic        p8;
    logic [3:0]  nib;
    logic        p6;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    ft = 1'b1;
    tick();
    ft = 1'b0;
  endtask

  task automatic idle();
    bus.joy_i       = '0;
    bus.turbo_en_i  = '0;
    bus.spin_en_i   = '0;
    bus.ctrl_p5_i   = '1;
    bus.ctrl_p8_i   = '1;
    bus0.joy_i      = '0;
    bus0.turbo_en_i = '0;
    bus0.spin_en_i  = '0;
    bus0.ctrl_p5_i  = '1;
    bus0.ctrl_p8_i  = '1;
    clk_en          = 1'b0;
    ft              = 1'b0;
  endtask

  task automatic check_all_ones(input string name);
    check({name, "_ctrl"}, {16'h0, bus.ctrl_o}, 32'h0000_FFFF);
    check({name, "_p6"},   {28'h0, bus.ctrl_p6_o}, 32'hF);
    check({name, "_p7p9"}, {24'h0, bus.ctrl_p7_o, bus.ctrl_p9_o}, 32'hFF);
    check({name, "_dut0"}, {25'h0, bus0.ctrl_o, bus0.ctrl_p6_o, bus0.ctrl_p7_o, bus0.ctrl_p9_o}, 32'h7F);
  endtask

  logic [1:0] cw_seq  [4];
  logic [1:0] ccw_seq [4];

  initial begin
    cw_seq  = '{2'b11, 2'b10, 2'b00, 2'b01};
    ccw_seq = '{2'b11, 2'b01, 2'b00, 2'b10};

    //           joy            p5    p8    nib      p6
    vecs[0]  = '{32'h0000_0100, 1'b0, 1'b1, 4'b0011, 1'b1};  // 0
    vecs[1]  = '{32'h0000_0200, 1'b0, 1'b1, 4'b1110, 1'b1};  // 1
    vecs[2]  = '{32'h0000_0400, 1'b0, 1'b1, 4'b1101, 1'b1};  // 2
    vecs[3]  = '{32'h0000_8800, 1'b0, 1'b1, 4'b0110, 1'b1};  // 3 beats 7
    vecs[4]  = '{32'h0000_1000, 1'b0, 1'b1, 4'b0001, 1'b1};  // 4
    vecs[5]  = '{32'h0000_2000, 1'b0, 1'b1, 4'b1001, 1'b1};  // 5
    vecs[6]  = '{32'h0000_4000, 1'b0, 1'b1, 4'b0111, 1'b1};  // 6
    vecs[7]  = '{32'h0000_8000, 1'b0, 1'b1, 4'b1100, 1'b1};  // 7
    vecs[8]  = '{32'h0001_0000, 1'b0, 1'b1, 4'b1000, 1'b1};  // 8
    vecs[9]  = '{32'h0002_0000, 1'b0, 1'b1, 4'b1011, 1'b1};  // 9
    vecs[10] = '{32'h0000_0040, 1'b0, 1'b1, 4'b1010, 1'b1};  // *
    vecs[11] = '{32'h0000_0080, 1'b0, 1'b1, 4'b0101, 1'b1};  // #
    vecs[12] = '{32'h0004_0000, 1'b0, 1'b1, 4'b0100, 1'b1};  // Purple
    vecs[13] = '{32'h0008_0000, 1'b0, 1'b1, 4'b0010, 1'b1};  // Blue
    vecs[14] = '{32'h0008_0040, 1'b0, 1'b1, 4'b1010, 1'b1};  // * beats Blue
    vecs[15] = '{32'h0002_0080, 1'b0, 1'b1, 4'b1011, 1'b1};  // 9 beats #
    vecs[16] = '{32'h0000_0220, 1'b0, 1'b1, 4'b1110, 1'b0};  // Fire2 on p5
    vecs[17] = '{32'h0000_0210, 1'b0, 1'b1, 4'b1110, 1'b1};  // Fire1 needs p8
    vecs[18] = '{32'h0000_0008, 1'b1, 1'b0, 4'b0111, 1'b1};  // U
    vecs[19] = '{32'h0000_0001, 1'b1, 1'b0, 4'b1011, 1'b1};  // R
    vecs[20] = '{32'h0000_0004, 1'b1, 1'b0, 4'b1101, 1'b1};  // D
    vecs[21] = '{32'h0000_0002, 1'b1, 1'b0, 4'b1110, 1'b1};  // L
    vecs[22] = '{32'h0000_0019, 1'b1, 1'b0, 4'b0011, 1'b0};  // U+R+Fire1
    vecs[23] = '{32'h0000_0020, 1'b1, 1'b0, 4'b1111, 1'b1};  // Fire2 on p8
    vecs[24] = '{32'h0000_0438, 1'b0, 1'b0, 4'b0101, 1'b0};  // both strobes
    vecs[25] = '{32'h0000_0118, 1'b1, 1'b1, 4'b1111, 1'b1};  // no strobe

    // Reset with every input active
    idle();
    rst_n          = 1'b0;
    bus.joy_i      = '1;
    bus.turbo_en_i = '1;
    bus.spin_en_i  = '1;
    bus.ctrl_p5_i  = '0;
    bus.ctrl_p8_i  = '0;
    bus0.joy_i     = '1;
    bus0.ctrl_p5_i = '0;
    bus0.ctrl_p8_i = '0;
    bus0.spin_en_i = '1;
    clk_en         = 1'b1;
    ft             = 1'b1;
    repeat (3) tick();
    check_all_ones("reset");
    rst_n = 1'b1;
    check_all_ones("post_reset");
    idle();
    tick();
    check_all_ones("idle");

    // Table vectors on pad 0
    for (int i = 0; i < 26; i++) begin
      bus.joy_i[31:0]  = vecs[i].joy;
      bus.ctrl_p5_i[0] = vecs[i].p5;
      bus.ctrl_p8_i[0] = vecs[i].p8;
      tick();
      check($sformatf("vec%0d", i), {27'h0, bus.ctrl_o[3:0], bus.ctrl_p6_o[0]},
            {27'h0, vecs[i].nib, vecs[i].p6});
    end

    // Hold stretch: 3+7 held, release, expire on 5th frame tick
    idle();
    bus.ctrl_p5_i[0] = 1'b0;
    bus.joy_i[31:0]  = 32'h0000_8800;
    tick();
    check("hold_press", {28'h0, bus.ctrl_o[3:0]}, 32'h6);
    bus.joy_i[31:0] = '0;
    tick();
    check("hold_release", {28'h0, bus.ctrl_o[3:0]}, 32'h6);
    for (int k = 1; k <= 5; k++) begin
      frame();
      check($sformatf("hold_frame%0d", k), {28'h0, bus.ctrl_o[3:0]},
            (k < 5) ? 32'h6 : 32'hF);
    end

    // Override mid-stretch
    bus.joy_i[31:0] = 32'h0000_2000;
    tick();
    check("ovr_press5", {28'h0, bus.ctrl_o[3:0]}, 32'h9);
    bus.joy_i[31:0] = '0;
    frame();
    frame();
    check("ovr_stretch", {28'h0, bus.ctrl_o[3:0]}, 32'h9);
    bus.joy_i[31:0] = 32'h0000_0080;
    tick();
    check("ovr_hash", {28'h0, bus.ctrl_o[3:0]}, 32'h5);

    // Turbo on Fire1 via p8
    idle();
    bus.turbo_en_i[0] = 1'b1;
    bus.ctrl_p8_i[0]  = 1'b0;
    bus.joy_i[31:0]   = 32'h0000_0010;
    tick();
    check("turbo_f0", {31'h0, bus.ctrl_p6_o[0]}, 32'h0);
    for (int f = 1; f <= 8; f++) begin
      frame();
      check($sformatf("turbo_f%0d", f), {31'h0, bus.ctrl_p6_o[0]},
            (((f / 3) % 2) == 0) ? 32'h0 : 32'h1);
    end
    bus.turbo_en_i[0] = 1'b0;
    tick();
    check("turbo_off", {31'h0, bus.ctrl_p6_o[0]}, 32'h0);
    repeat (3) frame();
    check("turbo_off_frames", {31'h0, bus.ctrl_p6_o[0]}, 32'h0);

    // Spinner CW then CCW
    idle();
    bus.spin_en_i[0] = 1'b1;
    clk_en           = 1'b1;
    bus.joy_i[31:0]  = 32'h0020_0000;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("spin_cw%0d", k), {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]},
            {30'h0, cw_seq[(k / 4) % 4]});
    end
    bus.joy_i[31:0] = 32'h0010_0000;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("spin_ccw%0d", k), {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]},
            {30'h0, ccw_seq[(k / 4) % 4]});
    end
    bus.joy_i[31:0] = 32'h0020_0000;
    repeat (4) tick();
    check("spin_cw_10", {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]}, 32'h2);
    bus.joy_i[31:0] = 32'h0030_0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("spin_both%0d", k), {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]}, 32'h2);
    end
    bus.joy_i[31:0] = 32'h0020_0000;
    clk_en = 1'b0;
    repeat (6) tick();
    check("spin_no_en", {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]}, 32'h2);
    clk_en = 1'b1;
    repeat (4) tick();
    check("spin_cw_00", {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]}, 32'h0);
    repeat (2) tick();
    bus.joy_i[31:0] = 32'h0010_0000;
    tick();
    check("spin_rev_hold", {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]}, 32'h0);
    tick();
    check("spin_rev_step", {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]}, 32'h2);
    bus.spin_en_i[0] = 1'b0;
    tick();
    check("spin_disable", {30'h0, bus.ctrl_p7_o[0], bus.ctrl_p9_o[0]}, 32'h3);

    // Multi-pad isolation: digits 1,2,3,4 on pads 0..3
    idle();
    bus.joy_i     = {32'h0000_1000, 32'h0000_0800, 32'h0000_0400, 32'h0000_0200};
    bus.ctrl_p5_i = 4'b1010;
    tick();
    check("multi_a", {16'h0, bus.ctrl_o}, 32'h0000_F6FE);
    bus.ctrl_p5_i = 4'b0101;
    tick();
    check("multi_b", {16'h0, bus.ctrl_o}, 32'h0000_1FDF);
    bus.joy_i[95:64] = 32'h0000_0820;
    bus.ctrl_p5_i    = 4'b1011;
    tick();
    check("multi_c", {16'h0, bus.ctrl_o}, 32'h0000_F6FF);
    check("multi_p6", {28'h0, bus.ctrl_p6_o}, 32'hB);
    check("multi_p7p9", {24'h0, bus.ctrl_p7_o, bus.ctrl_p9_o}, 32'hFF);

    // HOLD_TICKS=0 variant follows raw with one clock of delay
    idle();
    bus0.ctrl_p5_i[0] = 1'b0;
    bus0.joy_i        = 32'h0000_1000;
    tick();
    check("hold0_press", {28'h0, bus0.ctrl_o}, 32'h1);
    bus0.joy_i = '0;
    tick();
    check("hold0_release", {28'h0, bus0.ctrl_o}, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
